// File: rtl/hilo_muldiv_ctrl_if.sv
// Request/result bundle between the execute stage and the HI/LO mul/div sequencer.
interface hilo_muldiv_ctrl_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; 33 edges from accept to commit.
// busy stalls the pipeline; start is ignored entirely while busy, MTHI/MTLO write in one edge.
module hilo_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    hilo_muldiv_ctrl_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               is_signed;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign is_signed = ~bus.op[0];
    assign a_abs     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_abs     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend bits being replaced by quotient bits}.
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

    // Divide-by-zero naturally leaves rem=|a| (sign-restored to a); only the quotient is forced.
    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = dbz_q ? {WIDTH{1'b1}} : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    assign rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dbz_d    = dbz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            neg_d    = is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            rneg_d   = is_signed & bus.a[WIDTH-1];
                            dbz_d    = bus.op[1] && (bus.b == '0);
                            is_div_d = bus.op[1];
                            cnt_d    = '0;
                            if (bus.op[1]) begin
                                acc_d   = {{WIDTH{1'b0}}, a_abs};
                                opnd_d  = b_abs;
                                state_d = S_DIV;
                            end else begin
                                acc_d   = {{WIDTH{1'b0}}, b_abs};
                                opnd_d  = a_abs;
                                state_d = S_MUL;
                            end
                        end
                        OP_MTHI: hi_d = bus.a;
                        OP_MTLO: lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                acc_d = (state_q == S_DIV) ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = S_FIX;
                end
            end
            default: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dbz_q    <= dbz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: directed vectors, results checked on each done pulse.
module tb_hilo_muldiv_ctrl;
    localparam int W = 32;

    localparam logic [2:0] MULT  = 3'b000;
    localparam logic [2:0] MULTU = 3'b001;
    localparam logic [2:0] DIV   = 3'b010;
    localparam logic [2:0] DIVU  = 3'b011;
    localparam logic [2:0] MTHI  = 3'b100;
    localparam logic [2:0] MTLO  = 3'b101;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hilo_muldiv_ctrl_if #(.WIDTH(W)) bus ();
    hilo_muldiv_ctrl #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int nvec = 0;
    int nmis = 0;
    logic [2*W-1:0] exp_q [$];
    logic [2*W-1:0] mon_e;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                nvec++;
                nmis++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation");
            end else begin
                mon_e = exp_q.pop_front();
                check("result_hi", bus.hi, mon_e[2*W-1:W]);
                check("result_lo", bus.lo, mon_e[W-1:0]);
            end
        end
    end

    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = (bus.busy === 1'b1) ? 1 : 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done === 1'b1) break;
            if (bus.busy === 1'b1) bc++;
        end
    endtask

    task automatic do_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2*W-1:0] exp);
        int lat, bc;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat, bc);
        check({name, "_latency"}, W'(lat), W'(33));
        check({name, "_busy_cycles"}, W'(bc), W'(33));
    endtask

    task automatic mt(input logic [2:0] op, input logic [W-1:0] a);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    initial begin
        int lat, bc;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hi", bus.hi, '0);
        check("reset_lo", bus.lo, '0);
        check("reset_busy", W'(bus.busy), '0);
        check("reset_done", W'(bus.done), '0);
        reset = 1'b1;

        mt(MTHI, 32'hCAFEF00D);
        check("mthi_hi", bus.hi, 32'hCAFEF00D);
        check("mthi_lo", bus.lo, '0);
        check("mthi_busy", W'(bus.busy), '0);
        check("mthi_done", W'(bus.done), '0);
        @(posedge clk);
        #1;

        do_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
        do_op("mult_neg", MULT, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1);
        do_op("mult_negneg", MULT, 32'hFFFFFFFC, 32'hFFFFFFFA, 64'h00000000_00000018);
        do_op("div_neg_a", DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
        do_op("div_neg_b", DIV, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
        do_op("divu_zero", DIVU, 32'h12345678, 32'd0, 64'h12345678_FFFFFFFF);
        do_op("div_zero_neg", DIV, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF);
        do_op("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);

        // Starts issued mid-run must be ignored, and HI/LO must hold.
        bus.start = 1'b1;
        bus.op    = MULTU;
        bus.a     = 32'd3;
        bus.b     = 32'd4;
        exp_q.push_back(64'h00000000_0000000C);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = MTLO;
        bus.a     = 32'h1;
        @(posedge clk);
        #1;
        bus.op = MULTU;
        bus.a  = 32'd5;
        bus.b  = 32'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("hold_hi", bus.hi, 32'h0);
        check("hold_lo", bus.lo, 32'h80000000);
        check("hold_busy", W'(bus.busy), W'(1));
        wait_done(lat, bc);
        check("ignored_start_latency", W'(lat), W'(26));

        // Reset in the middle of a divide discards it.
        mt(MTHI, 32'h5);
        mt(MTLO, 32'h5);
        check("pre_reset_hi", bus.hi, 32'h5);
        check("pre_reset_lo", bus.lo, 32'h5);
        bus.start = 1'b1;
        bus.op    = DIVU;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_hi", bus.hi, '0);
        check("midreset_lo", bus.lo, '0);
        check("midreset_busy", W'(bus.busy), '0);
        check("midreset_done", W'(bus.done), '0);
        reset = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("post_reset_busy", W'(bus.busy), '0);

        do_op("divu_100_7", DIVU, 32'd100, 32'd7, 64'h00000002_0000000E);
        do_op("b2b_multu", MULTU, 32'd2, 32'd3, 64'h00000000_00000006);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", W'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Multi-cycle sequencer for the multiply/divide instructions (MULT, MULTU, DIV, DIVU) and owner of the HI/LO register pair.
- Sits beside the single-cycle ALU in the execute stage.
- Runs a 32-step iterative shift-add multiply or restoring divide, applies the sign correction, and writes HI/LO.
- Asserts busy so the pipeline stalls any MFHI/MFLO or new mul/div until the result is committed.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
start  input  1  request; sampled only when busy=0
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved
a  input  WIDTH  rs operand; dividend / multiplicand / MTHI/MTLO source
b  input  WIDTH  rt operand; divisor / multiplier
busy  output  1  high while a mul/div is in flight
done  output  1  one-cycle pulse in the cycle after HI/LO commit
hi  output  WIDTH  HI register contents
lo  output  WIDTH  LO register contents

Behaviour:
- Reset (reset=0 at a rising edge): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Any in-flight operation is discarded with no HI/LO write.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start=1, op in {000..011} at edge E0:
  - Latch operands. Signed ops latch absolute values and record the quotient/product sign (a[31]^b[31]) and the dividend sign (a[31]).
  - Go to MUL or DIV, counter=0, busy=1 from the cycle after E0.
- IDLE, start=1, op=100/101 at E0: hi (or lo) <= a. Stay in IDLE; busy and done remain 0.
- IDLE, start=1, op=110/111: ignored.
- MUL, edges E1..E32: one shift-add step per edge over a 2*WIDTH accumulator; counter increments. At counter=WIDTH-1 go to FIX.
- DIV, edges E1..E32: one restoring-division step per edge (shift remainder, trial subtract, set quotient bit); counter increments. At counter=WIDTH-1 go to FIX.
- FIX, edge E33:
  - Apply two's-complement negation where required.
  - Write hi/lo. MUL: hi=product[63:32], lo=product[31:0]. DIV: lo=quotient, hi=remainder.
  - Return to IDLE with busy=0 and done=1 for exactly one cycle.
  - Total latency: 33 edges from the E0 that accepted start to the HI/LO commit.
- Signed results:
  - Product is negated if the sign bits differ.
  - Quotient truncates toward zero.
  - Remainder takes the dividend's sign.
- Arithmetic widths:
  - All intermediate arithmetic is unsigned WIDTH+1 bit for the divide and 2*WIDTH bit for the multiply.
  - Negation wraps modulo 2^WIDTH, so DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (DIV or DIVU): takes the full 33 edges; lo=0xFFFFFFFF, hi=a (the original operand, not its absolute value).
- start while busy=1: ignored for every op, including MTHI/MTLO. Operands and HI/LO are undisturbed.
- hi/lo hold their previous values throughout MUL/DIV/FIX and change only at the FIX edge, on MTHI/MTLO, or on reset.
- done and a new start: start may be asserted in the same cycle done=1 (busy is already 0) and is accepted.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy high 33 cycles; at done: hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678 after 33 edges. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0xCAFEF00D in IDLE -> hi=0xCAFEF00D next cycle, busy=0, done=0. Then MULTU 3*4 in progress with MTLO a=0x1 and a second MULTU issued mid-run -> both ignored; final lo=0xC, hi=0.
- Reset asserted low at edge E10 of a DIVU 100/7 with prior hi=lo=0x5 -> next cycle hi=lo=0, busy=0, no done pulse. After release, DIVU 100/7 -> lo=14, hi=2.
- Back-to-back: new MULTU 2*3 asserted in the done cycle of the previous op -> accepted; its done arrives 33 edges later with lo=6.
